// File: rtl/fp_accumulator.sv
// Sequential single-precision float accumulator: sums a vector of operands terminated by in_last,
// optionally clamps a negative sum to +0, and hands the result out over valid/ready.
module fp_accumulator #(
  parameter int BIAS = 127,
  parameter bit RELU = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  // Largest normal biased exponent; anything above it saturates.
  localparam logic [9:0] EXP_MAX = 10'(2 * BIAS);

  typedef enum logic [1:0] {IDLE = 2'd0, ALIGN = 2'd1, ADD = 2'd2, OUT = 2'd3} state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, op_q, out_data_q;
  logic        last_q, in_ready_q, out_valid_q, sign_q, sub_q;
  logic [7:0]  exp_q;
  logic [23:0] mbig_q, msmall_q;

  logic        acc_big_s, sign_s;
  logic [30:0] big_s, small_s;
  logic [7:0]  ediff_s;
  logic [23:0] mb_s, ms_s;
  logic [24:0] sum_s;
  logic [4:0]  lz_s;
  logic [23:0] mant_s;
  logic [9:0]  expw_s;
  logic [31:0] res_s;

  function automatic logic [4:0] lzc24(input logic [23:0] v);
    logic found;
    lzc24 = 5'd0;
    found = 1'b0;
    for (int i = 23; i >= 0; i--) begin
      if (found) begin
        found = 1'b1;
      end else if (v[i]) begin
        found = 1'b1;
      end else begin
        lzc24 = lzc24 + 5'd1;
      end
    end
  endfunction

  // Alignment: pick the larger magnitude and right-shift the smaller mantissa.
  always_comb begin
    acc_big_s = (acc_q[30:0] >= op_q[30:0]);
    if (acc_big_s) begin
      big_s   = acc_q[30:0];
      small_s = op_q[30:0];
      sign_s  = acc_q[31];
    end else begin
      big_s   = op_q[30:0];
      small_s = acc_q[30:0];
      sign_s  = op_q[31];
    end
    ediff_s = big_s[30:23] - small_s[30:23];
    mb_s    = (big_s == 31'd0) ? 24'd0 : {1'b1, big_s[22:0]};
    ms_s    = (small_s == 31'd0) ? 24'd0 : {1'b1, small_s[22:0]};
    if (ediff_s >= 8'd24) begin
      ms_s = 24'd0;
    end else begin
      ms_s = ms_s >> ediff_s;
    end
  end

  // Add/subtract, normalise, then clamp the exponent range.
  always_comb begin
    sum_s = sub_q ? ({1'b0, mbig_q} - {1'b0, msmall_q}) : ({1'b0, mbig_q} + {1'b0, msmall_q});
    lz_s  = 5'd0;
    if (sub_q) begin
      lz_s   = lzc24(sum_s[23:0]);
      mant_s = sum_s[23:0] << lz_s;
      expw_s = {2'b00, exp_q} - {5'd0, lz_s};
    end else if (sum_s[24]) begin
      mant_s = sum_s[24:1];
      expw_s = {2'b00, exp_q} + 10'd1;
    end else begin
      mant_s = sum_s[23:0];
      expw_s = {2'b00, exp_q};
    end
    // expw_s[9] set means the subtraction wrapped below zero.
    if (mant_s == 24'd0) begin
      res_s = 32'h0000_0000;
    end else if (expw_s[9] || (expw_s == 10'd0)) begin
      res_s = 32'h0000_0000;
    end else if (expw_s > EXP_MAX) begin
      res_s = {sign_q, EXP_MAX[7:0], 23'h7F_FFFF};
    end else begin
      res_s = {sign_q, expw_s[7:0], mant_s[22:0]};
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (in_valid && in_ready_q) ? ALIGN : IDLE;
      ALIGN:   state_d = ADD;
      ADD:     state_d = last_q ? OUT : IDLE;
      OUT:     state_d = (out_valid_q && out_ready) ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers; out_valid rises one cycle after entering OUT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= 32'h0000_0000;
      op_q        <= 32'h0000_0000;
      last_q      <= 1'b0;
      sign_q      <= 1'b0;
      sub_q       <= 1'b0;
      exp_q       <= 8'h00;
      mbig_q      <= 24'h00_0000;
      msmall_q    <= 24'h00_0000;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= 32'h0000_0000;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d == IDLE);
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            op_q   <= in_data;
            last_q <= in_last;
          end
        end
        ALIGN: begin
          sign_q   <= sign_s;
          sub_q    <= acc_q[31] ^ op_q[31];
          exp_q    <= big_s[30:23];
          mbig_q   <= mb_s;
          msmall_q <= ms_s;
        end
        ADD: acc_q <= res_s;
        OUT: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= (RELU && acc_q[31]) ? 32'h0000_0000 : acc_q;
          end else if (out_ready) begin
            out_valid_q <= 1'b0;
            acc_q       <= 32'h0000_0000;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_fp_accumulator.sv
// Bench for fp_accumulator: table of vectors checked through a scoreboard queue against two
// instances (RELU=1 and RELU=0), plus hand-written backpressure and mid-vector reset sequences.
module tb_fp_accumulator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_data = 32'h0;
  logic        in_ready_a, out_valid_a, in_ready_b, out_valid_b;
  logic [31:0] out_data_a, out_data_b;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0][31:0] ops;
    logic [1:0]       n;
    logic [31:0]      e1;
    logic [31:0]      e0;
  } vec_t;

  typedef struct packed {
    logic [31:0] e1;
    logic [31:0] e0;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[9];

  fp_accumulator #(.BIAS(127), .RELU(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_a), .out_ready(out_ready), .out_data(out_data_a)
  );

  fp_accumulator #(.BIAS(127), .RELU(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int n, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] e1, input logic [31:0] e0);
    vec_t v;
    v.n = 2'(n);
    v.ops[0] = a;
    v.ops[1] = b;
    v.ops[2] = c;
    v.e1 = e1;
    v.e0 = e0;
    return v;
  endfunction

  // Called at #1 after a rising edge; returns the edge count at which the operand was accepted.
  task automatic send_op(input logic [31:0] d, input logic l, output int acc_cyc);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready_a && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready_a) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout actual=0 expected=1");
    end
    @(posedge clk); #1;
    acc_cyc  = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input string nm, input int last_cyc, input int hold);
    exp_t e;
    int   k;
    e = '0;
    k = 0;
    while (!out_valid_a && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({nm, "_latency"}, 32'(cyc - last_cyc), 32'd3);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_scoreboard_empty actual=0 expected=1", nm);
    end else begin
      e = sb.pop_front();
      check({nm, "_relu1"}, out_data_a, e.e1);
      check({nm, "_relu0"}, out_data_b, e.e0);
      check({nm, "_valid_b"}, {31'd0, out_valid_b}, 32'd1);
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      check({nm, "_hold_data"}, out_data_a, e.e1);
      check({nm, "_hold_valid"}, {31'd0, out_valid_a}, 32'd1);
      check({nm, "_hold_in_ready"}, {31'd0, in_ready_a}, 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({nm, "_valid_drop"}, {31'd0, out_valid_a}, 32'd0);
    check({nm, "_in_ready_back"}, {31'd0, in_ready_a}, 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input string nm, input int hold);
    int   c_prev, c_now;
    exp_t e;
    c_prev = 0;
    c_now  = 0;
    for (int i = 0; i < int'(v.n); i++) begin
      send_op(v.ops[i], (i == int'(v.n) - 1), c_now);
      if (i > 0) check({nm, "_gap"}, 32'(c_now - c_prev), 32'd3);
      c_prev = c_now;
    end
    e.e1 = v.e1;
    e.e0 = v.e0;
    sb.push_back(e);
    collect(nm, c_now, hold);
  endtask

  initial begin
    int c;
    int seen;
    tbl[0] = mk(2, 32'h3F800000, 32'h40000000, 32'h0, 32'h40400000, 32'h40400000);
    tbl[1] = mk(2, 32'h3FC00000, 32'hBFC00000, 32'h0, 32'h00000000, 32'h00000000);
    tbl[2] = mk(1, 32'h80000000, 32'h0, 32'h0, 32'h00000000, 32'h00000000);
    tbl[3] = mk(1, 32'hC0000000, 32'h0, 32'h0, 32'h00000000, 32'hC0000000);
    tbl[4] = mk(2, 32'h4B800000, 32'h3F800000, 32'h0, 32'h4B800000, 32'h4B800000);
    tbl[5] = mk(2, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h0, 32'h7F7FFFFF, 32'h7F7FFFFF);
    tbl[6] = mk(2, 32'h40000000, 32'hBF800000, 32'h0, 32'h3F800000, 32'h3F800000);
    tbl[7] = mk(2, 32'hBF800000, 32'h3F000000, 32'h0, 32'h00000000, 32'hBF000000);
    tbl[8] = mk(3, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40400000, 32'h40400000);

    repeat (3) @(posedge clk);
    #1;
    check("reset_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("reset_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("reset_out_data", out_data_a, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 9; i++) run_vec(tbl[i], $sformatf("v%0d", i), 0);

    // Backpressure: five stalled cycles, accept on the sixth, next vector starts from zero.
    out_ready = 1'b0;
    run_vec(mk(1, 32'h3F800000, 32'h0, 32'h0, 32'h3F800000, 32'h3F800000), "bp", 5);
    run_vec(mk(1, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 32'h40000000), "bp_next", 0);

    // Reset while the last operand sits in ADD.
    send_op(32'h3F800000, 1'b1, c);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
    check("rst_out_data", out_data_a, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid_a || out_valid_b) seen++;
    end
    check("rst_no_valid", 32'(seen), 32'd0);
    run_vec(mk(1, 32'h40000000, 32'h0, 32'h0, 32'h40000000, 32'h40000000), "post_rst", 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
